// File: rtl/eth_rx_frame_buffer.sv
// Store-and-forward receive buffer: commits only complete, error-free, address-matching
// frames and replays them on an AXI-Stream master; rejected frames are rolled back whole.
module eth_rx_frame_buffer #(
  parameter int DEPTH = 4096,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  input  logic [47:0] local_mac,
  input  logic        promisc,
  output logic        good_frame,
  output logic        drop_bad_frame,
  output logic        drop_filter,
  output logic        drop_overflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_P = (ADDR_WIDTH + 1)'(DEPTH);

  logic [8:0]          mem [DEPTH];
  logic [ADDR_WIDTH:0] wr_cur, wr_commit, rd;
  logic                drop_flag;
  logic [2:0]          byte_cnt;
  logic                ucast_match, bcast;
  logic [7:0]          mac_byte;
  logic                ucast_now, bcast_now, pass, full, wr_en;

  // Occupancy is judged from registered pointers only; a same-cycle read frees space next cycle.
  assign full  = (wr_cur - rd) == DEPTH_P;
  assign wr_en = s_axis_tvalid & ~drop_flag & ~full;

  always_comb begin
    mac_byte = 8'h00;
    case (byte_cnt)
      3'd0: mac_byte = local_mac[47:40];
      3'd1: mac_byte = local_mac[39:32];
      3'd2: mac_byte = local_mac[31:24];
      3'd3: mac_byte = local_mac[23:16];
      3'd4: mac_byte = local_mac[15:8];
      3'd5: mac_byte = local_mac[7:0];
      default: mac_byte = 8'h00;
    endcase
  end

  // Match flags including the current byte, so a tlast on byte 5 is judged on all six.
  assign ucast_now = ucast_match & ((byte_cnt >= 3'd6) | (s_axis_tdata == mac_byte));
  assign bcast_now = bcast & ((byte_cnt >= 3'd6) | (s_axis_tdata == 8'hff));
  assign pass      = promisc | ((byte_cnt >= 3'd5) & (ucast_now | bcast_now));

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt    <= 3'd0;
      ucast_match <= 1'b1;
      bcast       <= 1'b1;
    end else if (s_axis_tvalid) begin
      if (s_axis_tlast) begin
        byte_cnt    <= 3'd0;
        ucast_match <= 1'b1;
        bcast       <= 1'b1;
      end else begin
        if (byte_cnt < 3'd6) byte_cnt <= byte_cnt + 3'd1;
        ucast_match <= ucast_now;
        bcast       <= bcast_now;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_cur[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cur         <= '0;
      wr_commit      <= '0;
      drop_flag      <= 1'b0;
      good_frame     <= 1'b0;
      drop_bad_frame <= 1'b0;
      drop_filter    <= 1'b0;
      drop_overflow  <= 1'b0;
    end else begin
      good_frame     <= 1'b0;
      drop_bad_frame <= 1'b0;
      drop_filter    <= 1'b0;
      drop_overflow  <= 1'b0;
      if (s_axis_tvalid) begin
        if (drop_flag) begin
          if (s_axis_tlast) begin
            drop_flag     <= 1'b0;
            drop_overflow <= 1'b1;
          end
        end else if (full) begin
          wr_cur <= wr_commit;
          if (s_axis_tlast) drop_overflow <= 1'b1;
          else              drop_flag     <= 1'b1;
        end else if (s_axis_tlast) begin
          if (s_axis_tuser) begin
            wr_cur         <= wr_commit;
            drop_bad_frame <= 1'b1;
          end else if (!pass) begin
            wr_cur      <= wr_commit;
            drop_filter <= 1'b1;
          end else begin
            wr_cur     <= wr_cur + 1'b1;
            wr_commit  <= wr_cur + 1'b1;
            good_frame <= 1'b1;
          end
        end else begin
          wr_cur <= wr_cur + 1'b1;
        end
      end
    end
  end

  // Output handshake: a beat transfers when m_axis_tvalid & m_axis_tready; while tvalid is
  // high and tready low, tdata/tlast hold and tvalid stays up until the transfer happens.
  logic       p_valid;
  logic [8:0] p_data;
  logic       out_load, rd_en;

  assign out_load = p_valid & (~m_axis_tvalid | m_axis_tready);
  assign rd_en    = (rd != wr_commit) & (~p_valid | out_load);

  always_ff @(posedge clk) begin
    if (rd_en) p_data <= mem[rd[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd            <= '0;
      p_valid       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 8'h00;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (rd_en)         p_valid <= 1'b1;
      else if (out_load) p_valid <= 1'b0;
      if (rd_en) rd <= rd + 1'b1;
      if (out_load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= p_data[8];
        m_axis_tdata  <= p_data[7:0];
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
// Bench for eth_rx_frame_buffer: a 64-byte and a 128-byte instance share stimulus, one
// selected at a time; expected beats and status pulses come from a frame-level model.
module tb_eth_rx_frame_buffer;

  localparam logic [3:0] K_GOOD = 4'b1000;
  localparam logic [3:0] K_BAD  = 4'b0100;
  localparam logic [3:0] K_FILT = 4'b0010;
  localparam logic [3:0] K_OVF  = 4'b0001;
  localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;
  localparam logic [47:0] BCAST = 48'hff_ff_ff_ff_ff_ff;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  tdata;
  logic        tvalid, tlast, tuser, tready, promisc, big, rand_rdy;
  logic [47:0] local_mac;

  logic [7:0] s_m_data, b_m_data;
  logic s_m_valid, s_m_last, s_good, s_bad, s_filt, s_ovf;
  logic b_m_valid, b_m_last, b_good, b_bad, b_filt, b_ovf;

  eth_rx_frame_buffer #(.DEPTH(64)) dut_s (
    .clk(clk), .rst(rst),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid & ~big), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .m_axis_tdata(s_m_data), .m_axis_tvalid(s_m_valid), .m_axis_tready(tready), .m_axis_tlast(s_m_last),
    .local_mac(local_mac), .promisc(promisc),
    .good_frame(s_good), .drop_bad_frame(s_bad), .drop_filter(s_filt), .drop_overflow(s_ovf)
  );

  eth_rx_frame_buffer #(.DEPTH(128)) dut_b (
    .clk(clk), .rst(rst),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid & big), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .m_axis_tdata(b_m_data), .m_axis_tvalid(b_m_valid), .m_axis_tready(tready), .m_axis_tlast(b_m_last),
    .local_mac(local_mac), .promisc(promisc),
    .good_frame(b_good), .drop_bad_frame(b_bad), .drop_filter(b_filt), .drop_overflow(b_ovf)
  );

  logic [7:0] m_data;
  logic       m_valid, m_last;
  logic [3:0] pulses;
  assign m_data  = big ? b_m_data : s_m_data;
  assign m_valid = big ? b_m_valid : s_m_valid;
  assign m_last  = big ? b_m_last : s_m_last;
  assign pulses  = big ? {b_good, b_bad, b_filt, b_ovf} : {s_good, s_bad, s_filt, s_ovf};

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  logic [3:0] pk_q[$];
  int         pc_q[$];
  logic [7:0] frm[$];
  int total = 0;
  int bad = 0;
  int out_lasts = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  logic       prev_stall = 1'b0;
  logic [8:0] prev_beat;
  logic [3:0] ek;
  logic [8:0] eb;
  int         ec;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (pulses != 4'b0) begin
        total++;
        if (pk_q.size() == 0) begin
          bad++;
          $display("FAIL pulse: got %b at cycle %0d, expected none", pulses, cyc);
        end else begin
          ek = pk_q.pop_front();
          ec = pc_q.pop_front();
          if (pulses != ek || cyc != ec) begin
            bad++;
            $display("FAIL pulse: got %b at cycle %0d, expected %b at cycle %0d", pulses, cyc, ek, ec);
          end
        end
      end
      if (prev_stall) begin
        total++;
        if (!m_valid || {m_last, m_data} != prev_beat) begin
          bad++;
          $display("FAIL stall_hold: got valid=%b beat=%h expected valid=1 beat=%h", m_valid, {m_last, m_data}, prev_beat);
        end
      end
      if (m_valid && tready) begin
        total++;
        if (m_last) out_lasts++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL out_beat: got %h expected no output", {m_last, m_data});
        end else begin
          eb = exp_q.pop_front();
          if ({m_last, m_data} != eb) begin
            bad++;
            $display("FAIL out_beat: got %h expected %h", {m_last, m_data}, eb);
          end
        end
      end
      prev_stall = m_valid && !tready;
      prev_beat  = {m_last, m_data};
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      tready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic build(input logic [47:0] dst, input int len);
    frm.delete();
    for (int i = 0; i < len; i++)
      frm.push_back(i < 6 ? dst[47-8*i -: 8] : 8'($urandom));
  endtask

  task automatic beat(input logic [7:0] d, input logic l, input logic u);
    tdata = d; tlast = l; tuser = u; tvalid = 1'b1;
    step(1);
  endtask

  // Model: overflow known by the scenario, else tuser, else destination filter decides.
  task automatic send_frame(input logic u, input bit ovf);
    logic [47:0] d;
    bit          pass;
    logic [3:0]  k;
    d = '0;
    for (int i = 0; i < 6 && i < frm.size(); i++) d[47-8*i -: 8] = frm[i];
    pass = promisc || (frm.size() >= 6 && (d == local_mac || d == BCAST));
    if (ovf)        k = K_OVF;
    else if (u)     k = K_BAD;
    else if (!pass) k = K_FILT;
    else begin
      k = K_GOOD;
      for (int i = 0; i < frm.size(); i++) exp_q.push_back({i == frm.size() - 1, frm[i]});
    end
    pk_q.push_back(k);
    pc_q.push_back(cyc + frm.size());
    for (int i = 0; i < frm.size(); i++) beat(frm[i], i == frm.size() - 1, u);
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pk_q.size() != 0 || m_valid) && n < 5000) begin
      step(1);
      n++;
    end
    total++;
    if (n >= 5000) begin
      bad++;
      $display("FAIL %s: timeout with exp_q=%0d pulses_pending=%0d expected both 0", nm, exp_q.size(), pk_q.size());
      exp_q.delete(); pk_q.delete(); pc_q.delete();
    end
    step(3);
  endtask

  task automatic wait_pulses(input string nm);
    int n;
    n = 0;
    while (pk_q.size() != 0 && n < 2000) begin
      step(1);
      n++;
    end
    total++;
    if (n >= 2000) begin
      bad++;
      $display("FAIL %s: pulse timeout, pending=%0d expected 0", nm, pk_q.size());
      pk_q.delete(); pc_q.delete();
    end
  endtask

  task automatic random_dst(output logic [47:0] d);
    int r;
    r = $urandom_range(0, 3);
    if (r == 0)      d = BCAST;
    else if (r == 1) d = {32'($urandom), 16'($urandom)};
    else             d = MAC;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [47:0] d;
    int base;
    rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; tdata = 8'h00;
    tready = 1'b1; promisc = 1'b0; big = 1'b0; rand_rdy = 1'b0; local_mac = MAC;
    step(3);
    rst = 1'b0;
    step(1);
    chk("reset_s_valid", s_m_valid, 0);
    chk("reset_s_out", {s_m_last, s_m_data}, 0);
    chk("reset_s_pulses", {s_good, s_bad, s_filt, s_ovf}, 0);
    chk("reset_b_valid", b_m_valid, 0);
    chk("reset_b_pulses", {b_good, b_bad, b_filt, b_ovf}, 0);

    // Basic good frame and its output latency.
    build(MAC, 10);
    send_frame(1'b0, 1'b0);
    chk("lat_good_pulse", s_good, 1);
    chk("lat_valid_n", s_m_valid, 0);
    step(1);
    chk("lat_valid_n1", s_m_valid, 0);
    step(1);
    chk("lat_valid_n2", s_m_valid, 1);
    chk("lat_byte0", s_m_data, 8'h02);
    wait_idle("basic");

    // Bad FCS, then a clean frame must carry no residue.
    build(MAC, 10); send_frame(1'b1, 1'b0);
    build(MAC, 15); send_frame(1'b0, 1'b0);
    wait_idle("bad_then_good");

    // Address filter cases.
    build(OTHER, 10); send_frame(1'b0, 1'b0);
    promisc = 1'b1;
    build(OTHER, 10); send_frame(1'b0, 1'b0);
    promisc = 1'b0;
    build(BCAST, 10); send_frame(1'b0, 1'b0);
    build(MAC, 4);    send_frame(1'b0, 1'b0);
    build(MAC, 6);    send_frame(1'b0, 1'b0);
    build(MAC, 5);    send_frame(1'b0, 1'b0);
    wait_idle("filter");

    // Overflow: A fills the stalled buffer; B cannot fit.
    tready = 1'b0;
    build(MAC, 40); send_frame(1'b0, 1'b0);
    step(2);
    build(MAC, 40); send_frame(1'b0, 1'b1);
    wait_pulses("overflow");
    chk("ovf_holding", s_m_valid, 1);
    tready = 1'b1;
    wait_idle("overflow_drain");
    chk("ovf_empty_after", s_m_valid, 0);

    // Random frames on the small buffer, output always ready.
    for (int f = 0; f < 20; f++) begin
      random_dst(d);
      promisc = ($urandom_range(0, 5) == 0);
      build(d, $urandom_range(1, 40));
      send_frame(1'b1 && ($urandom_range(0, 7) == 0), 1'b0);
      step($urandom_range(0, 3));
    end
    promisc = 1'b0;
    wait_idle("random_small");

    // Large buffer: back-to-back frames against random backpressure.
    big = 1'b1;
    rand_rdy = 1'b1;
    base = out_lasts;
    build(MAC, 60); send_frame(1'b0, 1'b0);
    build(MAC, 7);  send_frame(1'b0, 1'b0);
    build(MAC, 33); send_frame(1'b0, 1'b0);
    wait_idle("b2b");
    chk("b2b_tlast_count", out_lasts - base, 3);
    for (int f = 0; f < 8; f++) begin
      random_dst(d);
      build(d, $urandom_range(1, 100));
      send_frame(1'b1 && ($urandom_range(0, 5) == 0), 1'b0);
      wait_idle("random_big");
    end
    rand_rdy = 1'b0;
    step(1);
    tready = 1'b1;
    step(2);

    // Reset in the middle of an incoming frame.
    build(MAC, 20);
    for (int i = 0; i < 5; i++) beat(frm[i], 1'b0, 1'b0);
    tvalid = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrst_valid", b_m_valid, 0);
    chk("midrst_out", {b_m_last, b_m_data}, 0);
    chk("midrst_pulses", {b_good, b_bad, b_filt, b_ovf}, 0);
    step(5);
    chk("midrst_quiet", {b_m_valid, b_good, b_bad, b_filt, b_ovf}, 0);
    build(MAC, 12); send_frame(1'b0, 1'b0);
    wait_idle("after_reset");

    // Reset while a committed frame waits for output: nothing may emerge.
    tready = 1'b0;
    build(MAC, 10); send_frame(1'b0, 1'b0);
    wait_pulses("pre_reset_frame");
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    exp_q.delete();
    tready = 1'b1;
    step(10);
    chk("rst_discard_valid", b_m_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_rx_frame_buffer.md
Name: eth_rx_frame_buffer

Overview:
Store-and-forward receive frame buffer that sits directly downstream of the GMII/MII frame receiver. It accepts that receiver's 8-bit AXI stream, which has no tready, and never stalls it. Only complete, error-free frames that pass the destination-MAC filter are committed. Committed frames are presented on a standard AXI-Stream master with backpressure. Bad-FCS/errored frames, filtered frames and frames that do not fit are discarded whole by pointer rollback.

Parameters:
DEPTH, 4096, buffer capacity in bytes; power of two, minimum 64
ADDR_WIDTH, $clog2(DEPTH), buffer address width (derived, not overridden)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
s_axis_tdata  input  8  received byte
s_axis_tvalid  input  1  byte valid; no ready, must be accepted every cycle
s_axis_tlast  input  1  last byte of frame
s_axis_tuser  input  1  on the tlast beat: 1 = bad frame (error/FCS)
m_axis_tdata  output  8  buffered byte
m_axis_tvalid  output  1  output valid
m_axis_tready  input  1  downstream ready
m_axis_tlast  output  1  last byte of committed frame
local_mac  input  48  station address; byte 0 on the wire = local_mac[47:40]
promisc  input  1  1 = accept any destination address
good_frame  output  1  one-cycle pulse: frame committed
drop_bad_frame  output  1  one-cycle pulse: frame dropped, tuser=1
drop_filter  output  1  one-cycle pulse: frame dropped, address mismatch
drop_overflow  output  1  one-cycle pulse: frame dropped, buffer full

Behaviour:
- Storage: DEPTH x 9-bit RAM holding {last, data}. Pointers wr_cur, wr_commit and rd are each ADDR_WIDTH+1 bits wide and wrap naturally.
- full = (wr_cur - rd == DEPTH). The comparison uses the registered rd. A byte read in the same cycle frees space only from the next cycle.
- Write side, per s_axis beat:
  - drop_flag set: discard the byte. On tlast, clear drop_flag and pulse drop_overflow.
  - full: set drop_flag and restore wr_cur to wr_commit. If this beat is tlast, pulse drop_overflow immediately and leave drop_flag clear.
  - otherwise: write mem[wr_cur] = {tlast, tdata} and increment wr_cur.
- Once a frame overflows, it stays dropped even if space frees later in the same frame. A frame longer than DEPTH always overflows.
- Filter logic:
  - A byte counter saturates at 6 and clears after each tlast.
  - ucast_match and bcast flags are evaluated over bytes 0..5.
  - pass = promisc | (count reached 6 & (ucast_match | bcast)). A frame shorter than 6 bytes fails unless promisc is set.
- Decision on a non-overflowed tlast beat, in priority order:
  - tuser=1: wr_cur <= wr_commit; pulse drop_bad_frame.
  - else !pass: wr_cur <= wr_commit; pulse drop_filter.
  - else: wr_commit <= wr_cur+1; pulse good_frame.
- Pulses are registered and high in the cycle after the tlast beat, coincident with the commit. Exactly one pulse is issued per input frame.
- Read side:
  - A RAM read pipeline register feeds an output register (skid), sustaining 1 beat/cycle while m_axis_tready=1.
  - A read is issued when rd != wr_commit and the pipeline has room.
  - Only committed bytes are ever read.
- Latency: with the buffer and pipeline empty, good_frame high in cycle N gives m_axis_tvalid high in cycle N+2 with byte 0.
- AXI rules:
  - m_axis_tdata and m_axis_tlast are held stable while m_axis_tvalid=1 and m_axis_tready=0.
  - m_axis_tvalid is never deasserted without a handshake.
  - Frames are output in arrival order, byte-exact.
- Reset: all pointers 0, drop_flag=0, byte counter 0, pipeline empty.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - good_frame, drop_bad_frame, drop_filter and drop_overflow all 0.
- Reset mid-frame: the partial frame is lost with no pulse. The first beat after reset starts a new frame. Reset mid-output discards all buffered data.
- Simultaneous write and read: both proceed independently in the same cycle. An empty/full decision never uses a same-cycle update.

Test Plan:
- DEPTH=64, promisc=0, local_mac=02:00:00:00:00:01, tready=1. Send a 10-byte frame to that address, tuser=0 -> one good_frame pulse. m_axis_tvalid rises 2 cycles later; 10 identical bytes follow, tlast on the 10th only.
- Same frame with tuser=1 on tlast -> drop_bad_frame pulse, no output. A following good frame emerges intact with no residue.
- Destination 02:00:00:00:00:02 -> drop_filter. Repeat with promisc=1 -> output. Destination FF:FF:FF:FF:FF:FF with promisc=0 -> output. 4-byte frame with promisc=0 -> drop_filter.
- tready=0; send 40-byte good frame A, then 40-byte frame B -> good_frame for A; drop_overflow at B's tlast. Then set tready=1 -> exactly 40 bytes (A) out, m_axis_tvalid then 0.
- Three back-to-back good frames (60, 7, 33 bytes; DEPTH=128) with random tready -> all bytes in order. tdata/tlast stable during every stall; 3 tlast beats total.
- Assert rst for 1 cycle at beat 5 of a 20-byte frame -> no pulse, no output, all status outputs 0. The next 12-byte good frame is output correctly.
